// File: rtl/i2c_slave_ctrl_rw.sv
// I2C slave transaction controller with register pointer: master-write loads the
// pointer then writes a limited burst, master-read streams bytes from the pointer.
module i2c_slave_ctrl_rw #(
  parameter int PTR_WIDTH = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_found,
  input  logic                 stop_found,
  input  logic                 byte_received,
  input  logic                 ack_prep,
  input  logic                 check_ack,
  input  logic                 ack_done,
  input  logic                 rw_mode,
  input  logic                 address_match,
  input  logic                 sda_in,
  input  logic [7:0]           rx_data,
  output logic                 rx_enable,
  output logic                 tx_enable,
  output logic [1:0]           sda_mode,
  output logic                 load_data,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic [PTR_WIDTH-1:0] ptr,
  output logic                 busy
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  localparam logic [1:0] SDA_RELEASE = 2'b00;
  localparam logic [1:0] SDA_ACK     = 2'b01;
  localparam logic [1:0] SDA_NACK    = 2'b10;
  localparam logic [1:0] SDA_TX      = 2'b11;

  typedef enum logic [4:0] {
    IDLE, START_RCVD, CHECK_ADDR, SEND_NACK, ACK_ADDR_W, RX_PTR, LOAD_PTR,
    ACK_PTR, RX_DATA, WRITE_DATA, ACK_DATA, ACK_ADDR_R, LOAD_DATA, SEND_BYTE,
    CHECK_ACK, INC_PNTR, ACK_RCVD, NACK_RCVD, WAIT_MASTER
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]           burst_q, burst_d;

  // Only the low PTR_WIDTH bits of a pointer byte are meaningful.
  logic rx_data_unused;
  assign rx_data_unused = ^rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    burst_d      = burst_q;
    rx_enable    = 1'b0;
    tx_enable    = 1'b0;
    sda_mode     = SDA_RELEASE;
    load_data    = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_found) state_d = START_RCVD;
      end
      START_RCVD: begin
        rx_enable = 1'b1;
        burst_d   = '0;
        if (byte_received) state_d = CHECK_ADDR;
      end
      CHECK_ADDR: begin
        if (!address_match) state_d = SEND_NACK;
        else if (rw_mode)   state_d = ACK_ADDR_R;
        else                state_d = ACK_ADDR_W;
      end
      SEND_NACK: begin
        sda_mode = SDA_NACK;
        if (ack_done) state_d = IDLE;
      end
      ACK_ADDR_W: begin
        sda_mode = SDA_ACK;
        if (ack_done) state_d = RX_PTR;
      end
      RX_PTR: begin
        rx_enable = 1'b1;
        if (byte_received) state_d = LOAD_PTR;
      end
      LOAD_PTR: begin
        ptr_d   = rx_data[PTR_WIDTH-1:0];
        state_d = ACK_PTR;
      end
      ACK_PTR: begin
        sda_mode = SDA_ACK;
        if (ack_done) state_d = RX_DATA;
      end
      RX_DATA: begin
        rx_enable = 1'b1;
        if (byte_received) begin
          // The byte past the burst limit is refused without a write.
          if (burst_q >= MAX_BURST_C) state_d = SEND_NACK;
          else                        state_d = WRITE_DATA;
        end
      end
      WRITE_DATA: begin
        write_enable = 1'b1;
        ptr_d        = ptr_q + PTR_WIDTH'(1);
        if (burst_q < MAX_BURST_C) burst_d = burst_q + 8'd1;
        state_d      = ACK_DATA;
      end
      ACK_DATA: begin
        sda_mode = SDA_ACK;
        if (ack_done) state_d = RX_DATA;
      end
      ACK_ADDR_R: begin
        sda_mode = SDA_ACK;
        if (ack_done) state_d = LOAD_DATA;
      end
      LOAD_DATA: begin
        load_data = 1'b1;
        state_d   = SEND_BYTE;
      end
      SEND_BYTE: begin
        tx_enable = 1'b1;
        sda_mode  = SDA_TX;
        if (ack_prep) state_d = CHECK_ACK;
      end
      CHECK_ACK: begin
        if (check_ack) state_d = sda_in ? NACK_RCVD : INC_PNTR;
      end
      INC_PNTR: begin
        read_enable = 1'b1;
        ptr_d       = ptr_q + PTR_WIDTH'(1);
        state_d     = ACK_RCVD;
      end
      ACK_RCVD: begin
        if (ack_done) state_d = LOAD_DATA;
      end
      NACK_RCVD: begin
        if (ack_done) state_d = WAIT_MASTER;
      end
      WAIT_MASTER: begin
        state_d = WAIT_MASTER;
      end
      default: state_d = IDLE;
    endcase

    // Bus-level stop/start override whatever the current state decided.
    if (state_q != IDLE) begin
      if (stop_found)       state_d = IDLE;
      else if (start_found) state_d = START_RCVD;
    end
  end

  assign ptr  = ptr_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_slave_ctrl_rw.sv
// Bench for i2c_slave_ctrl_rw: drives bus-event pulses and compares against a
// transaction-level model of pointer, burst limit and ACK/NACK behaviour.
module tb_i2c_slave_ctrl_rw;

  localparam int PW    = 4;
  localparam int MB    = 2;
  localparam int DEPTH = 1 << PW;

  localparam int P_START = 0, P_STOP = 1, P_BYTE = 2, P_PREP = 3, P_CHK = 4, P_DONE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_found = 1'b0, stop_found = 1'b0, byte_received = 1'b0;
  logic          ack_prep = 1'b0, check_ack = 1'b0, ack_done = 1'b0;
  logic          rw_mode = 1'b0, address_match = 1'b0, sda_in = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_enable, tx_enable, load_data, write_enable, read_enable, busy;
  logic [1:0]    sda_mode;
  logic [PW-1:0] ptr;

  int errors = 0;
  int checks = 0;
  int mptr   = 0;

  logic [PW-1:0] wr_addr_q[$];
  logic [7:0]    wr_data_q[$];
  logic [PW-1:0] ld_q[$];
  int            re_cnt = 0;

  i2c_slave_ctrl_rw #(.PTR_WIDTH(PW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
    .ack_done(ack_done), .rw_mode(rw_mode), .address_match(address_match),
    .sda_in(sda_in), .rx_data(rx_data), .rx_enable(rx_enable), .tx_enable(tx_enable),
    .sda_mode(sda_mode), .load_data(load_data), .write_enable(write_enable),
    .read_enable(read_enable), .ptr(ptr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_enable) begin
      wr_addr_q.push_back(ptr);
      wr_data_q.push_back(rx_data);
    end
    if (load_data) ld_q.push_back(ptr);
    if (read_enable) re_cnt = re_cnt + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      P_START: start_found   = 1'b1;
      P_STOP:  stop_found    = 1'b1;
      P_BYTE:  byte_received = 1'b1;
      P_PREP:  ack_prep      = 1'b1;
      P_CHK:   check_ack     = 1'b1;
      default: ack_done      = 1'b1;
    endcase
    @(negedge clk);
    {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = '0;
  endtask

  task automatic send_addr(input bit rw, input bit match);
    rx_data       = {7'h2A, rw};
    rw_mode       = rw;
    address_match = match;
    pulse(P_BYTE);
    idle(1);
  endtask

  // Master write: address, pointer byte, n data bytes, optional stop.
  task automatic write_txn(input logic [7:0] pb, input int n, input bit do_stop);
    logic [7:0]    d[8];
    logic [PW-1:0] ea;
    logic [1:0]    es;
    int            p0, nw;
    bit            nacked;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse(P_START);
    send_addr(1'b0, 1'b1);
    checks++;
    if (sda_mode !== 2'b01) begin errors++; $display("FAIL w_addr_ack: got %b exp 01", sda_mode); end
    pulse(P_DONE);
    rx_data = pb;
    pulse(P_BYTE);
    idle(1);
    p0 = int'(pb) % DEPTH;
    ea = PW'(p0);
    checks++;
    if (ptr !== ea) begin errors++; $display("FAIL ptr_load: got %0d exp %0d", ptr, ea); end
    checks++;
    if (sda_mode !== 2'b01) begin errors++; $display("FAIL ptr_ack: got %b exp 01", sda_mode); end
    pulse(P_DONE);
    nw     = (n < MB) ? n : MB;
    nacked = 1'b0;
    for (int i = 0; i < n && i < 8; i++) begin
      d[i]    = 8'($urandom);
      rx_data = d[i];
      pulse(P_BYTE);
      idle(1);
      es = (i < MB) ? 2'b01 : 2'b10;
      checks++;
      if (sda_mode !== es) begin errors++; $display("FAIL data_ack[%0d]: got %b exp %b", i, sda_mode, es); end
      pulse(P_DONE);
      if (i >= MB) begin
        nacked = 1'b1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL burst_nack_idle: got busy=%b exp 0", busy); end
        break;
      end
    end
    if (do_stop && !nacked) begin
      pulse(P_STOP);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL w_stop_idle: got busy=%b exp 0", busy); end
    end
    checks++;
    if (wr_addr_q.size() != nw) begin
      errors++; $display("FAIL write_count: got %0d exp %0d", wr_addr_q.size(), nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        ea = PW'((p0 + i) % DEPTH);
        checks++;
        if (wr_addr_q[i] !== ea || wr_data_q[i] !== d[i]) begin
          errors++;
          $display("FAIL write[%0d]: got addr %0d data %h exp addr %0d data %h",
                   i, wr_addr_q[i], wr_data_q[i], ea, d[i]);
        end
      end
    end
    mptr = (p0 + nw) % DEPTH;
    ea   = PW'(mptr);
    checks++;
    if (ptr !== ea) begin errors++; $display("FAIL w_final_ptr: got %0d exp %0d", ptr, ea); end
  endtask

  // Master read of k bytes from the current pointer; last byte NACKed, then stop.
  task automatic read_txn(input int k);
    logic [PW-1:0] ea;
    int            p0;
    ld_q.delete();
    re_cnt = 0;
    p0     = mptr;
    pulse(P_START);
    send_addr(1'b1, 1'b1);
    checks++;
    if (sda_mode !== 2'b01) begin errors++; $display("FAIL r_addr_ack: got %b exp 01", sda_mode); end
    pulse(P_DONE);
    for (int i = 0; i < k; i++) begin
      idle(1);
      checks++;
      if (sda_mode !== 2'b11 || tx_enable !== 1'b1) begin
        errors++; $display("FAIL send_byte[%0d]: got sda=%b tx=%b exp 11/1", i, sda_mode, tx_enable);
      end
      sda_in = (i == k - 1);
      pulse(P_PREP);
      checks++;
      if (sda_mode !== 2'b00) begin errors++; $display("FAIL check_ack_release: got %b exp 00", sda_mode); end
      pulse(P_CHK);
      if (i < k - 1) idle(1);
      pulse(P_DONE);
    end
    sda_in = 1'b1;
    idle(3);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL wait_master: got busy=%b exp 1", busy); end
    pulse(P_STOP);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL r_stop_idle: got busy=%b exp 0", busy); end
    checks++;
    if (ld_q.size() != k) begin
      errors++; $display("FAIL load_count: got %0d exp %0d", ld_q.size(), k);
    end else begin
      for (int i = 0; i < k; i++) begin
        ea = PW'((p0 + i) % DEPTH);
        checks++;
        if (ld_q[i] !== ea) begin errors++; $display("FAIL load[%0d]: got %0d exp %0d", i, ld_q[i], ea); end
      end
    end
    checks++;
    if (re_cnt != k - 1) begin errors++; $display("FAIL read_enable_count: got %0d exp %0d", re_cnt, k - 1); end
    mptr = (p0 + k - 1) % DEPTH;
    ea   = PW'(mptr);
    checks++;
    if (ptr !== ea) begin errors++; $display("FAIL r_final_ptr: got %0d exp %0d", ptr, ea); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if ({rx_enable, tx_enable, sda_mode, load_data, write_enable, read_enable, busy, ptr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rx=%b tx=%b sda=%b ld=%b we=%b re=%b busy=%b ptr=%0d exp all 0",
               rx_enable, tx_enable, sda_mode, load_data, write_enable, read_enable, busy, ptr);
    end
    rst  = 1'b0;
    mptr = 0;
    idle(1);
  endtask

  task automatic test_write_basic();
    write_txn(8'h03, 2, 1'b1);
  endtask

  task automatic test_ptr_wrap();
    write_txn(8'hFF, 2, 1'b1);
  endtask

  task automatic test_burst_limit();
    write_txn(8'h09, MB + 1, 1'b1);
  endtask

  task automatic test_write_then_read();
    write_txn(8'h06, 0, 1'b0);
    read_txn(3);
  endtask

  task automatic test_addr_nack();
    pulse(P_START);
    send_addr(1'b0, 1'b0);
    checks++;
    if (sda_mode !== 2'b10 || rx_enable !== 1'b0) begin
      errors++; $display("FAIL addr_nack: got sda=%b rx=%b exp 10/0", sda_mode, rx_enable);
    end
    pulse(P_DONE);
    pulse(P_BYTE);
    checks++;
    if (busy !== 1'b0 || rx_enable !== 1'b0) begin
      errors++; $display("FAIL addr_nack_idle: got busy=%b rx=%b exp 0/0", busy, rx_enable);
    end
  endtask

  task automatic enter_send_byte();
    pulse(P_START);
    send_addr(1'b1, 1'b1);
    pulse(P_DONE);
    idle(1);
    checks++;
    if (tx_enable !== 1'b1) begin errors++; $display("FAIL reach_send_byte: got tx=%b exp 1", tx_enable); end
  endtask

  task automatic test_start_stop_collision();
    enter_send_byte();
    @(negedge clk);
    start_found = 1'b1;
    stop_found  = 1'b1;
    @(negedge clk);
    start_found = 1'b0;
    stop_found  = 1'b0;
    checks++;
    if (busy !== 1'b0 || sda_mode !== 2'b00) begin
      errors++; $display("FAIL start_stop_collision: got busy=%b sda=%b exp 0/00", busy, sda_mode);
    end
  endtask

  task automatic test_reset_mid_txn();
    write_txn(8'h0B, 1, 1'b1);
    enter_send_byte();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    mptr = 0;
    checks++;
    if ({rx_enable, tx_enable, sda_mode, load_data, write_enable, read_enable, busy, ptr} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got tx=%b sda=%b busy=%b ptr=%0d exp all 0", tx_enable, sda_mode, busy, ptr);
    end
    idle(2);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_stays_idle: got busy=%b exp 0", busy); end
    pulse(P_START);
    checks++;
    if (busy !== 1'b1 || rx_enable !== 1'b1) begin
      errors++; $display("FAIL restart_after_reset: got busy=%b rx=%b exp 1/1", busy, rx_enable);
    end
    pulse(P_STOP);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      write_txn(8'($urandom), $urandom_range(0, MB + 1), 1'($urandom_range(0, 1)));
      read_txn($urandom_range(1, 4));
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_ptr_wrap();
    test_burst_limit();
    test_write_then_read();
    test_addr_nack();
    test_start_stop_collision();
    test_reset_mid_txn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_slave_ctrl_rw.md
Name: i2c_slave_ctrl_rw

Overview:
- Next-generation I2C slave controller with a register pointer. Supports master-write (pointer byte, then N data bytes) and master-read (N bytes from the pointer, auto-increment).
- Sits between the existing start/stop detector, timer, shift registers and a register file of 2^PTR_WIDTH bytes.
- Adds over the previous controller: write path, pointer load and wrap, burst limit with NACK, repeated-start and stop abort from any state.

Parameters:
- PTR_WIDTH, 4, width of register pointer; register file depth = 2^PTR_WIDTH.
- MAX_BURST, 8, max data bytes accepted per write transaction (1..255); byte MAX_BURST+1 is NACKed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start_found  in  1  start/repeated-start detected (1-cycle pulse)
- stop_found  in  1  stop detected (1-cycle pulse)
- byte_received  in  1  8 bits shifted in (pulse)
- ack_prep  in  1  tx byte fully shifted, ACK slot next (pulse)
- check_ack  in  1  sample point of master ACK bit (pulse)
- ack_done  in  1  ACK/NACK bit period finished (pulse)
- rw_mode  in  1  R/W bit of address byte, 1 = master read
- address_match  in  1  address byte matches slave address
- sda_in  in  1  synchronised SDA
- rx_data  in  8  last received byte
- rx_enable  out  1  enable rx shift register
- tx_enable  out  1  enable tx shift register
- sda_mode  out  2  00 release, 01 drive ACK (low), 10 drive NACK (high), 11 drive tx bit
- load_data  out  1  load tx shift register from regfile[ptr]
- write_enable  out  1  write rx_data to regfile[ptr]
- read_enable  out  1  pulse on each master-ACKed read byte
- ptr  out  PTR_WIDTH  current register pointer
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst sampled at posedge clk. State = IDLE, ptr = 0, burst count = 0, all outputs 0.
- Decode: outputs are combinational from state (Moore). ptr, burst count and state are registered.
- Global abort, highest priority, evaluated in every non-IDLE state:
  - stop_found -> IDLE.
  - else start_found -> START_RCVD (repeated start).
  - Simultaneous start and stop: stop wins.
- IDLE: start_found -> START_RCVD.
- START_RCVD: rx_enable = 1; burst count cleared; byte_received -> CHECK_ADDR.
- CHECK_ADDR: 1 cycle.
  - !address_match -> SEND_NACK.
  - address_match & rw_mode -> ACK_ADDR_R.
  - address_match & !rw_mode -> ACK_ADDR_W.
- SEND_NACK: sda_mode = 10; ack_done -> IDLE.
- ACK_ADDR_W: sda_mode = 01; ack_done -> RX_PTR.
- RX_PTR: rx_enable = 1; byte_received -> LOAD_PTR.
- LOAD_PTR: 1 cycle; ptr <= rx_data[PTR_WIDTH-1:0]; upper bits ignored; -> ACK_PTR.
- ACK_PTR: sda_mode = 01; ack_done -> RX_DATA.
- RX_DATA: rx_enable = 1; on byte_received:
  - burst count == MAX_BURST -> SEND_NACK (no write).
  - else -> WRITE_DATA.
- WRITE_DATA: 1 cycle.
  - write_enable = 1 with ptr = write address.
  - At the end of the cycle: ptr <= ptr+1 mod 2^PTR_WIDTH; burst count +1.
  - -> ACK_DATA.
- ACK_DATA: sda_mode = 01; ack_done -> RX_DATA.
- ACK_ADDR_R: sda_mode = 01; ack_done -> LOAD_DATA.
- LOAD_DATA: 1 cycle; load_data = 1; -> SEND_BYTE.
- SEND_BYTE: tx_enable = 1, sda_mode = 11; ack_prep -> CHECK_ACK.
- CHECK_ACK: sda_mode = 00; on check_ack:
  - sda_in = 0 -> INC_PNTR.
  - sda_in = 1 -> NACK_RCVD.
- INC_PNTR: 1 cycle; read_enable = 1; ptr <= ptr+1 (wraps); -> ACK_RCVD.
- ACK_RCVD: ack_done -> LOAD_DATA.
- NACK_RCVD: ack_done -> WAIT_MASTER.
- WAIT_MASTER: waits for the global abort only.
- ptr persistence:
  - ptr persists across transactions, so write-pointer, repeated start, then read returns from the loaded pointer.
  - ptr changes only in LOAD_PTR, WRITE_DATA, INC_PNTR and on rst.
- Burst count: width 8, saturates at MAX_BURST, does not count read bytes.
- Reset mid-transaction: immediate return to reset values; a subsequent transaction requires a fresh start_found.

Test Plan:
- Write ptr 0x03 then 2 bytes 0xA5, 0x5A, then stop -> write_enable pulses with ptr = 3, then ptr = 4; final ptr = 5; ACK (sda_mode 01) on address, pointer and both data bytes; IDLE after stop.
- PTR_WIDTH = 4: write ptr 0xFF, 2 data bytes -> writes at 15 then 0; final ptr = 1.
- MAX_BURST = 2: pointer plus 3 data bytes -> 2 write_enable pulses; third byte gets sda_mode 10, no write; IDLE after its ack_done.
- Write ptr 0x06, repeated start, read with master ACK, ACK, NACK, stop -> load_data ×3 at ptr 6, 7, 8; read_enable ×2; final ptr = 8; WAIT_MASTER then IDLE.
- address_match = 0 -> sda_mode 10 for the ACK slot, no rx of further bytes, IDLE; start_found and stop_found together in SEND_BYTE -> IDLE.
- rst asserted during SEND_BYTE -> next cycle IDLE, ptr = 0, all outputs 0; a following start_found -> START_RCVD.
